relay_bank_ctrl: RTL and testbench
==================================

# relay_bank_ctrl

Parametrised, multi-channel successor to the single-channel relay and timed-switch device models. It drives CH switch-enable outputs from either sampled control codes (hysteresis comparator with debounce) or a per-channel one-shot timer. Each channel is selected per mode and reports a one-cycle change event. It sits between the sampled-control datapath and the switch/relay resistance stage.

## Interface
Parameters:
- CH, 4: number of channels
- W, 12: control code width (unsigned)
- VT, 2048: switching threshold code
- VH, 205: hysteresis half-width code
- SETTLE, 4: consecutive qualifying samples required to switch (≥1)
- TW, 16: timer width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  in_code holds a new sample for all channels this cycle
- in_code  in  CH*W  channel i at bits [i*W +: W]
- mode  in  CH  per channel: 0 = comparator, 1 = timer
- init  in  CH  per-channel reset state of sw_on
- t_load  in  CH  timer mode: load and start countdown from t_val
- t_val  in  TW  shared countdown length in cycles
- sw_on  out  CH  switch closed
- sw_evt  out  CH  one-cycle pulse on every sw_on change
- busy  out  CH  channel has a pending transition (debounce or timer running)

## Operation
- Per-channel FSM states: OFF, ON_PEND, ON, OFF_PEND. TIMER is a flag ORed onto OFF/ON.
- Thresholds are computed in W+1 bits:
  - TH_ON = min(VT+VH, 2^W−1)
  - TH_OFF = max(VT−VH, 0)
- Comparator mode transitions:
  - OFF: in_valid and code > TH_ON → ON_PEND, cnt=1. If SETTLE=1, go directly to ON.
  - ON_PEND: each valid sample with code > TH_ON increments cnt. When cnt reaches SETTLE → ON.
  - ON_PEND: a valid sample with code ≤ TH_ON → OFF, cnt=0.
  - ON/OFF_PEND: mirror image using code < TH_OFF.
  - If TH_OFF=0, the channel never turns off.
  - Codes between the thresholds hold the current state. In pending states they abort to the stable state.
  - Cycles without in_valid hold state and cnt.
- Timer mode:
  - t_load with t_val≠0 starts the countdown (busy=1).
  - sw_on toggles exactly t_val cycles after the load cycle; busy clears on the same edge.
  - t_load while running restarts from the new t_val.
  - t_load with t_val=0 is ignored, as is t_load in comparator mode.
- Mode change on any cycle aborts the pending debounce or timer: cnt/timer cleared, busy=0, sw_on held, no sw_evt.
- Channels are fully independent. Simultaneous events on multiple channels are all honoured in the same cycle.

## Timing
- Reset values: sw_on=init, sw_evt=0, busy=0, all cnt/timers 0, FSM = ON if init else OFF.
- Reset asserted mid-transition discards it with no sw_evt.
- Comparator latency: sw_on changes on the clock edge that samples the SETTLE-th qualifying in_valid; sw_evt is high the following cycle only. With SETTLE=1, sw_on updates on the same edge as the qualifying sample.
- Timer latency: load at edge k → sw_on toggles at edge k+t_val.
- busy is registered. It goes high on the edge that enters a pending state or loads the timer.
- No combinational path from any input to any output.

## Structure
- Package relay_pkg: state enum (OFF, ON_PEND, ON, OFF_PEND), mode constants MODE_CMP=0/MODE_TMR=1, threshold helper functions (saturating TH_ON/TH_OFF).
- Sub-module relay_ch: one channel (FSM, debounce counter of width $clog2(SETTLE+1), TW-bit timer).
- The top level is a generate loop over CH instances plus bus slicing.

## Test plan
- Reset with init=4'b0101 → sw_on=0101, busy=0, sw_evt=0 on the first cycle after rst deasserts.
- Ch0 comparator, VT=2048, VH=205, SETTLE=4: four valid samples of 2300 → sw_on[0]=1 at the 4th sample edge, single sw_evt[0] pulse. Then 2100 × 10 → stays 1. Then 1800 × 4 → off.
- Debounce abort: 2300, 2300, 2100, 2300 ×3 → no switch. A 4th consecutive 2300 → on. Invalid gaps between qualifying samples do not reset cnt.
- Ch2 timer: t_val=10, t_load at cycle 5 → sw_on[2] toggles at cycle 15, busy[2] high cycles 6–15. Reload t_val=3 at cycle 12 → toggle at cycle 15 from the new count. t_val=0 load → nothing happens.
- Simultaneous: ch0 and ch1 reach SETTLE on the same edge while ch3 timer expires → all three sw_evt pulse together.
- Mode flip during ON_PEND, and rst during a running timer → no toggle, busy=0, sw_on unchanged or init respectively. VT=100, VH=205 → TH_OFF=0, so the channel never turns off.

Source files
------------

// File: rtl/relay_pkg.sv
// Shared types and helpers for the relay bank: channel state encoding,
// mode constants and saturating threshold arithmetic.
package relay_pkg;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_ON_PEND  = 2'd1,
    ST_ON       = 2'd2,
    ST_OFF_PEND = 2'd3
  } relay_state_t;

  localparam logic MODE_CMP = 1'b0;
  localparam logic MODE_TMR = 1'b1;

  // Upper switching threshold, clipped to the largest representable code.
  function automatic int th_on_calc(int vt, int vh, int w);
    int top_code;
    int sum;
    top_code = (1 << w) - 1;
    sum      = vt + vh;
    return (sum > top_code) ? top_code : sum;
  endfunction

  // Lower switching threshold, clipped at zero.
  function automatic int th_off_calc(int vt, int vh);
    return (vt > vh) ? (vt - vh) : 0;
  endfunction

endpackage

// File: rtl/relay_ch.sv
// One relay channel: hysteresis comparator with debounce, or a one-shot
// countdown timer that toggles the switch when it expires.
//
// Handshake: in_valid qualifies code for exactly the cycle it is high; there
// is no ready, every valid sample is consumed. t_load is a single-cycle
// command, honoured only in timer mode with a non-zero t_val.
import relay_pkg::*;

module relay_ch #(
  parameter int W      = 12,
  parameter int VT     = 2048,
  parameter int VH     = 205,
  parameter int SETTLE = 4,
  parameter int TW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  code,
  input  logic          mode,
  input  logic          init,
  input  logic          t_load,
  input  logic [TW-1:0] t_val,
  output logic          sw_on,
  output logic          sw_evt,
  output logic          busy
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  // Thresholds carried in W+1 bits so the saturated upper value never wraps.
  localparam logic [W:0]    TH_ON_X  = (W + 1)'(th_on_calc(VT, VH, W));
  localparam logic [W:0]    TH_OFF_X = (W + 1)'(th_off_calc(VT, VH));
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

  relay_state_t  state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] timer;
  logic          mode_q;
  logic          above;
  logic          below;
  logic          tmr_active;

  // code < TH_OFF written as code+1 <= TH_OFF: a zero lower threshold then
  // simply never qualifies, so the channel can never switch off.
  assign above      = ({1'b0, code} > TH_ON_X);
  assign below      = (({1'b0, code} + 1'b1) <= TH_OFF_X);
  assign tmr_active = (timer != '0);

  // Channel FSM, debounce counter, countdown timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= init ? ST_ON : ST_OFF;
      sw_on  <= init;
      sw_evt <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
      timer  <= '0;
      mode_q <= mode;
    end else begin
      mode_q <= mode;
      sw_evt <= 1'b0;
      if (mode != mode_q) begin
        // Any mode change abandons whatever was pending; the switch holds.
        state <= sw_on ? ST_ON : ST_OFF;
        cnt   <= '0;
        timer <= '0;
        busy  <= 1'b0;
      end else if (mode == MODE_TMR) begin
        if (t_load && (t_val != '0)) begin
          timer <= t_val;
          busy  <= 1'b1;
        end else if (tmr_active) begin
          if (timer == TW'(1)) begin
            timer  <= '0;
            busy   <= 1'b0;
            sw_on  <= ~sw_on;
            sw_evt <= 1'b1;
            state  <= sw_on ? ST_OFF : ST_ON;
          end else begin
            timer <= timer - 1'b1;
          end
        end
      end else if (in_valid) begin
        case (state)
          ST_OFF: begin
            if (above) begin
              if (SETTLE == 1) begin
                state  <= ST_ON;
                sw_on  <= 1'b1;
                sw_evt <= 1'b1;
              end else begin
                state <= ST_ON_PEND;
                cnt   <= CW'(1);
                busy  <= 1'b1;
              end
            end
          end
          ST_ON_PEND: begin
            if (!above) begin
              state <= ST_OFF;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == LAST_CNT) begin
              state  <= ST_ON;
              cnt    <= '0;
              busy   <= 1'b0;
              sw_on  <= 1'b1;
              sw_evt <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_ON: begin
            if (below) begin
              if (SETTLE == 1) begin
                state  <= ST_OFF;
                sw_on  <= 1'b0;
                sw_evt <= 1'b1;
              end else begin
                state <= ST_OFF_PEND;
                cnt   <= CW'(1);
                busy  <= 1'b1;
              end
            end
          end
          ST_OFF_PEND: begin
            if (!below) begin
              state <= ST_ON;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt == LAST_CNT) begin
              state  <= ST_OFF;
              cnt    <= '0;
              busy   <= 1'b0;
              sw_on  <= 1'b0;
              sw_evt <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= sw_on ? ST_ON : ST_OFF;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/relay_bank_ctrl.sv
// Bank of independent relay channels sharing one clock, sample strobe and
// timer length; each channel is sliced out of the packed buses.
import relay_pkg::*;

module relay_bank_ctrl #(
  parameter int CH     = 4,
  parameter int W      = 12,
  parameter int VT     = 2048,
  parameter int VH     = 205,
  parameter int SETTLE = 4,
  parameter int TW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CH*W-1:0] in_code,
  input  logic [CH-1:0]   mode,
  input  logic [CH-1:0]   init,
  input  logic [CH-1:0]   t_load,
  input  logic [TW-1:0]   t_val,
  output logic [CH-1:0]   sw_on,
  output logic [CH-1:0]   sw_evt,
  output logic [CH-1:0]   busy
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    relay_ch #(
      .W      (W),
      .VT     (VT),
      .VH     (VH),
      .SETTLE (SETTLE),
      .TW     (TW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .code     (in_code[i*W +: W]),
      .mode     (mode[i]),
      .init     (init[i]),
      .t_load   (t_load[i]),
      .t_val    (t_val),
      .sw_on    (sw_on[i]),
      .sw_evt   (sw_evt[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_relay_bank_ctrl.sv
// Bench for relay_bank_ctrl: two instances (default thresholds with SETTLE=4,
// and VT=100/SETTLE=1 where the lower threshold clips to zero) share one
// stimulus stream and are compared to a cycle-level behavioural model.
module tb_relay_bank_ctrl;

  localparam int CH = 4;
  localparam int W  = 12;
  localparam int TW = 16;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid;
  logic [CH*W-1:0] in_code;
  logic [CH-1:0]   mode;
  logic [CH-1:0]   init;
  logic [CH-1:0]   t_load;
  logic [TW-1:0]   t_val;

  logic [CH-1:0] on_o[2];
  logic [CH-1:0] evt_o[2];
  logic [CH-1:0] busy_o[2];

  relay_bank_ctrl #(.CH(CH), .W(W), .VT(2048), .VH(205), .SETTLE(4), .TW(TW)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .mode(mode),
    .init(init), .t_load(t_load), .t_val(t_val),
    .sw_on(on_o[0]), .sw_evt(evt_o[0]), .busy(busy_o[0])
  );

  relay_bank_ctrl #(.CH(CH), .W(W), .VT(100), .VH(205), .SETTLE(1), .TW(TW)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .mode(mode),
    .init(init), .t_load(t_load), .t_val(t_val),
    .sw_on(on_o[1]), .sw_evt(evt_o[1]), .busy(busy_o[1])
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural reference model ----------------
  // Each channel is a switch plus a run-length of consecutive qualifying
  // samples and an absolute deadline cycle for the timer (-1 = idle).
  int            th_on_m[2];
  int            th_off_m[2];
  int            settle_m[2];
  logic [CH-1:0] m_on[2];
  logic [CH-1:0] m_evt[2];
  logic [CH-1:0] m_busy[2];
  int            streak[2][CH];
  int            deadline[2][CH];
  logic          prev_mode[2][CH];
  int            cyc = 0;

  task automatic model_step();
    int  c;
    bit  qual;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < CH; i++) begin
        m_evt[d][i] = 1'b0;
        if (rst) begin
          m_on[d][i]     = init[i];
          streak[d][i]   = 0;
          deadline[d][i] = -1;
        end else if (mode[i] != prev_mode[d][i]) begin
          streak[d][i]   = 0;
          deadline[d][i] = -1;
        end else if (mode[i]) begin
          if (t_load[i] && t_val != 0) begin
            deadline[d][i] = cyc + int'(t_val);
          end else if (deadline[d][i] == cyc) begin
            m_on[d][i]     = ~m_on[d][i];
            m_evt[d][i]    = 1'b1;
            deadline[d][i] = -1;
          end
        end else if (in_valid) begin
          c    = int'(in_code[i*W +: W]);
          qual = m_on[d][i] ? (c < th_off_m[d]) : (c > th_on_m[d]);
          streak[d][i] = qual ? streak[d][i] + 1 : 0;
          if (streak[d][i] >= settle_m[d]) begin
            m_on[d][i]   = ~m_on[d][i];
            m_evt[d][i]  = 1'b1;
            streak[d][i] = 0;
          end
        end
        prev_mode[d][i] = mode[i];
        m_busy[d][i]    = (streak[d][i] > 0) || (deadline[d][i] >= 0);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs were set after the previous edge, outputs are
  // sampled 1 time unit after this edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_code(input int i, input int v);
    in_code[i*W +: W] = v[W-1:0];
  endtask

  task automatic set_all_codes(input int v);
    for (int i = 0; i < CH; i++) set_code(i, v);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    init = 4'b0101;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (on_o[d] !== 4'b0101) begin
        failures++;
        $display("FAIL reset_sw_on dut=%0d got=%b exp=0101", d, on_o[d]);
      end
      checks++;
      if (busy_o[d] !== 4'b0000 || evt_o[d] !== 4'b0000) begin
        failures++;
        $display("FAIL reset_busy_evt dut=%0d got busy=%b evt=%b exp 0000/0000", d, busy_o[d], evt_o[d]);
      end
    end
  endtask

  task automatic test_cmp_basic();
    init = 4'b0000;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    set_all_codes(2048);
    in_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      set_code(0, (k <= 4) ? 2300 : (k <= 14) ? 2100 : 1800);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({on_o[d], evt_o[d], busy_o[d]} !== {m_on[d], m_evt[d], m_busy[d]}) begin
          failures++;
          $display("FAIL cmp_basic_model dut=%0d k=%0d got on=%b evt=%b busy=%b exp on=%b evt=%b busy=%b",
                   d, k, on_o[d], evt_o[d], busy_o[d], m_on[d], m_evt[d], m_busy[d]);
        end
      end
      checks++;
      if (on_o[0][0] !== (k >= 4 && k < 18) || evt_o[0][0] !== (k == 4 || k == 18)) begin
        failures++;
        $display("FAIL cmp_basic_ch0 k=%0d got on=%b evt=%b exp on=%b evt=%b", k, on_o[0][0], evt_o[0][0],
                 (k >= 4 && k < 18), (k == 4 || k == 18));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_debounce_abort();
    int seq[] = '{2300, -1, 2300, 2100, 2300, -1, -1, 2300, 2300, 2300};
    set_all_codes(2048);
    foreach (seq[k]) begin
      in_valid = (seq[k] >= 0);
      if (seq[k] >= 0) set_code(0, seq[k]);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({on_o[d], evt_o[d], busy_o[d]} !== {m_on[d], m_evt[d], m_busy[d]}) begin
          failures++;
          $display("FAIL debounce_model dut=%0d k=%0d got on=%b evt=%b busy=%b exp on=%b evt=%b busy=%b",
                   d, k, on_o[d], evt_o[d], busy_o[d], m_on[d], m_evt[d], m_busy[d]);
        end
      end
      if (k == 8) begin
        checks++;
        if (on_o[0][0] !== 1'b0 || busy_o[0][0] !== 1'b1) begin
          failures++;
          $display("FAIL debounce_pending got on=%b busy=%b exp on=0 busy=1", on_o[0][0], busy_o[0][0]);
        end
      end
    end
    checks++;
    if (on_o[0][0] !== 1'b1 || evt_o[0][0] !== 1'b1) begin
      failures++;
      $display("FAIL debounce_switch got on=%b evt=%b exp on=1 evt=1", on_o[0][0], evt_o[0][0]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_timer();
    logic on_before;
    int   len[3] = '{10, 10, 0};
    int   run[3] = '{10, 7, 15};
    mode[2] = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      on_before = on_o[0][2];
      t_load[2] = 1'b1;
      t_val     = TW'(len[s]);
      tick();
      t_load = '0;
      for (int j = 1; j <= run[s]; j++) begin
        tick();
        for (int d = 0; d < 2; d++) begin
          checks++;
          if ({on_o[d], evt_o[d], busy_o[d]} !== {m_on[d], m_evt[d], m_busy[d]}) begin
            failures++;
            $display("FAIL timer_model dut=%0d s=%0d j=%0d got on=%b evt=%b busy=%b exp on=%b evt=%b busy=%b",
                     d, s, j, on_o[d], evt_o[d], busy_o[d], m_on[d], m_evt[d], m_busy[d]);
          end
        end
      end
      if (s == 1) begin
        // Restart mid-count with a shorter length: toggle 3 edges after reload.
        on_before = on_o[0][2];
        t_load[2] = 1'b1;
        t_val     = TW'(3);
        tick();
        t_load = '0;
        for (int j = 1; j <= 3; j++) begin
          checks++;
          if (on_o[0][2] !== on_before || busy_o[0][2] !== 1'b1) begin
            failures++;
            $display("FAIL timer_reload_wait j=%0d got on=%b busy=%b exp on=%b busy=1", j, on_o[0][2], busy_o[0][2], on_before);
          end
          tick();
        end
      end
      checks++;
      if (on_o[0][2] !== ((s == 2) ? on_before : ~on_before) || busy_o[0][2] !== 1'b0) begin
        failures++;
        $display("FAIL timer_expiry s=%0d got on=%b busy=%b exp on=%b busy=0", s, on_o[0][2], busy_o[0][2],
                 (s == 2) ? on_before : ~on_before);
      end
    end
    // A load aimed at a comparator-mode channel is ignored.
    on_before = on_o[0][0];
    t_load    = 4'b0001;
    t_val     = TW'(5);
    tick();
    t_load = '0;
    for (int j = 0; j < 8; j++) tick();
    checks++;
    if (on_o[0][0] !== on_before || busy_o[0][0] !== 1'b0) begin
      failures++;
      $display("FAIL timer_cmp_ignore got on=%b busy=%b exp on=%b busy=0", on_o[0][0], busy_o[0][0], on_before);
    end
  endtask

  task automatic test_simultaneous();
    mode[3] = 1'b1;
    tick();
    set_all_codes(2048);
    set_code(0, 1800);
    set_code(1, 2300);
    in_valid  = 1'b1;
    t_load[3] = 1'b1;
    t_val     = TW'(3);
    for (int k = 1; k <= 4; k++) begin
      tick();
      t_load = '0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({on_o[d], evt_o[d], busy_o[d]} !== {m_on[d], m_evt[d], m_busy[d]}) begin
          failures++;
          $display("FAIL simul_model dut=%0d k=%0d got on=%b evt=%b busy=%b exp on=%b evt=%b busy=%b",
                   d, k, on_o[d], evt_o[d], busy_o[d], m_on[d], m_evt[d], m_busy[d]);
        end
      end
    end
    checks++;
    if (evt_o[0] !== 4'b1011) begin
      failures++;
      $display("FAIL simul_evt got=%b exp=1011", evt_o[0]);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (evt_o[0] !== 4'b0000) begin
      failures++;
      $display("FAIL simul_evt_single got=%b exp=0000", evt_o[0]);
    end
  endtask

  task automatic test_mode_abort();
    logic [CH-1:0] on_before;
    set_all_codes(2048);
    set_code(1, 1800);
    in_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (busy_o[0][1] !== 1'b1 || on_o[0][1] !== 1'b1) begin
      failures++;
      $display("FAIL abort_pending got busy=%b on=%b exp busy=1 on=1", busy_o[0][1], on_o[0][1]);
    end
    mode[1] = 1'b1;
    tick();
    checks++;
    if (busy_o[0][1] !== 1'b0 || on_o[0][1] !== 1'b1 || evt_o[0][1] !== 1'b0) begin
      failures++;
      $display("FAIL abort_mode got busy=%b on=%b evt=%b exp 0/1/0", busy_o[0][1], on_o[0][1], evt_o[0][1]);
    end
    mode[1] = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (on_o[0][1] !== 1'b1 || busy_o[0][1] !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart got on=%b busy=%b exp on=1 busy=1", on_o[0][1], busy_o[0][1]);
    end
    in_valid  = 1'b0;
    // Reset while the ch2 timer is running.
    t_load[2] = 1'b1;
    t_val     = TW'(20);
    tick();
    t_load = '0;
    for (int j = 0; j < 5; j++) tick();
    init = 4'b1010;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (on_o[0] !== 4'b1010 || busy_o[0] !== 4'b0000 || evt_o[0] !== 4'b0000) begin
      failures++;
      $display("FAIL reset_timer got on=%b busy=%b evt=%b exp 1010/0000/0000", on_o[0], busy_o[0], evt_o[0]);
    end
    on_before = on_o[0];
    for (int j = 0; j < 25; j++) tick();
    checks++;
    if (on_o[0] !== on_before || busy_o[0] !== 4'b0000) begin
      failures++;
      $display("FAIL reset_timer_quiet got on=%b busy=%b exp on=%b busy=0000", on_o[0], busy_o[0], on_before);
    end
  endtask

  task automatic test_no_off();
    mode = 4'b0000;
    tick();
    in_valid = 1'b1;
    set_all_codes(500);
    tick();
    set_all_codes(0);
    for (int j = 0; j < 8; j++) tick();
    in_valid = 1'b0;
    checks++;
    if (on_o[1] !== 4'b1111) begin
      failures++;
      $display("FAIL no_off got=%b exp=1111", on_o[1]);
    end
    checks++;
    if ({on_o[0], evt_o[0], busy_o[0]} !== {m_on[0], m_evt[0], m_busy[0]}) begin
      failures++;
      $display("FAIL no_off_dut_a got on=%b evt=%b busy=%b exp on=%b evt=%b busy=%b",
               on_o[0], evt_o[0], busy_o[0], m_on[0], m_evt[0], m_busy[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 249) == 0);
      init     = CH'($urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < CH; i++) begin
        set_code(i, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(1700, 2400));
        if ($urandom_range(0, 59) == 0) mode[i] = ~mode[i];
        t_load[i] = ($urandom_range(0, 7) == 0);
      end
      t_val = TW'($urandom_range(0, 12));
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({on_o[d], evt_o[d], busy_o[d]} !== {m_on[d], m_evt[d], m_busy[d]}) begin
          failures++;
          $display("FAIL random_model dut=%0d n=%0d got on=%b evt=%b busy=%b exp on=%b evt=%b busy=%b",
                   d, n, on_o[d], evt_o[d], busy_o[d], m_on[d], m_evt[d], m_busy[d]);
        end
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    t_load   = '0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    th_on_m[0]  = (2048 + 205 > 4095) ? 4095 : 2048 + 205;
    th_off_m[0] = (2048 > 205) ? 2048 - 205 : 0;
    settle_m[0] = 4;
    th_on_m[1]  = (100 + 205 > 4095) ? 4095 : 100 + 205;
    th_off_m[1] = (100 > 205) ? 100 - 205 : 0;
    settle_m[1] = 1;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = '0;
    mode     = '0;
    init     = '0;
    t_load   = '0;
    t_val    = '0;
    #1;

    test_reset();
    test_cmp_basic();
    test_debounce_abort();
    test_timer();
    test_simultaneous();
    test_mode_abort();
    test_no_off();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
